vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_SYNC, 96: hsync width, pixels.
- H_BACK, 48: h back porch.
- H_ACT, 640: h active.
- H_FRONT, 16: h front porch.
- V_SYNC, 2: vsync width, lines.
- V_BACK, 33: v back porch.
- V_ACT, 480: v active.
- V_FRONT, 10: v front porch.
- HS_POL, 0: hsync active level.
- VS_POL, 0: vsync active level.
- COLOR_W, 8: bits per channel, legal 1..10.
- PIX_LAT, 2: request-to-data latency in enabled cycles, legal 1..4.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- iCLK, in, 1: clock.
- iRST_N, in, 1: reset, asynchronous, active-low.
- iEN, in, 1: pixel-clock enable.
- iRed / iGreen / iBlue, in, COLOR_W: pixel data returned for a request.
- oReq, out, 1: pixel request.
- oX, out, 11: requested column.
- oY, out, 11: requested row.
- oLineStart, out, 1: line-start pulse.
- oFrameStart, out, 1: frame-start pulse.
- oVGA_R / oVGA_G / oVGA_B, out, COLOR_W: colour outputs.
- oVGA_H_SYNC, out, 1: horizontal sync.
- oVGA_V_SYNC, out, 1: vertical sync.
- oVGA_BLANK, out, 1: 1 = active video.
- oVGA_SYNC, out, 1: tied 0.
- oVGA_CLK, out, 1: equals iCLK.

Function
REQ-003 Totals SHALL be H_TOTAL = H_SYNC+H_BACK+H_ACT+H_FRONT and V_TOTAL likewise; region order is sync, back, active, front.
REQ-004 hcnt SHALL count 0..H_TOTAL-1, advancing only when iEN=1, and wrap to 0 with no extra cycle.
REQ-005 vcnt SHALL advance only on the enabled cycle where hcnt wraps, and wrap from V_TOTAL-1 to 0.
REQ-006 When iEN=0, all counters, pipeline stages and outputs SHALL hold their values.
REQ-007 Stage-0 decode SHALL be combinational from the counters:
- hs0 = (hcnt < H_SYNC).
- vs0 = (vcnt < V_SYNC).
- de0 = hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACT) and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACT).
REQ-008 oReq SHALL equal de0 AND iEN.
REQ-009 oX SHALL be hcnt-(H_SYNC+H_BACK) and oY SHALL be vcnt-(V_SYNC+V_BACK) while de0=1, zero-extended to 11 bits; both SHALL be 0 while de0=0.
REQ-010 oLineStart SHALL be (hcnt==0 AND iEN).
REQ-011 oFrameStart SHALL be (hcnt==0 AND vcnt==0 AND iEN).
REQ-012 The requester SHALL present data for a request on iRed/iGreen/iBlue exactly PIX_LAT enabled cycles after that request; the block SHALL NOT buffer or flow-control this data.
REQ-013 hs0, vs0 and de0 SHALL be delayed PIX_LAT enabled cycles and then registered once more, together with the data, into the output registers.
REQ-014 Total latency from a counter state to the corresponding oVGA_* values SHALL be PIX_LAT+1 enabled cycles.
REQ-015 oVGA_R/G/B SHALL be the captured data when the delayed de=1, else 0.
REQ-016 oVGA_BLANK SHALL equal the delayed de.
REQ-017 oVGA_H_SYNC SHALL equal HS_POL when the delayed hs=1, else ~HS_POL; oVGA_V_SYNC likewise with VS_POL.
REQ-018 Illegal COLOR_W or PIX_LAT values SHALL stop elaboration with $error.

Reset
REQ-019 While iRST_N=0, the following SHALL hold, asynchronously:
- hcnt = vcnt = 0.
- Delay-line contents = 0.
- oVGA_R/G/B = 0 and oVGA_BLANK = 0.
- oVGA_H_SYNC = ~HS_POL and oVGA_V_SYNC = ~VS_POL.
REQ-020 Reset asserted mid-frame SHALL discard all in-flight pipeline contents.
REQ-021 The first enabled cycle after reset release SHALL present hcnt=0, vcnt=0 (oFrameStart=1).

Structure
REQ-022 Package vga_pkg SHALL hold:
- typedef vga_timing_t (eight porch/sync/active fields).
- Constants VGA_640x480_60 and VGA_800x600_60.
- Coordinate width constant VGA_COORD_W=11.
REQ-023 Sub-module vga_delay_line SHALL be a parametrised (WIDTH, DEPTH) enabled shift register with async reset, instantiated once for {hs,vs,de}.

Verification
REQ-024 Every scenario below SHALL use a small timing of H=2/2/4/2 (H_TOTAL 10) and V=1/1/3/1 (V_TOTAL 6), with PIX_LAT=2 unless stated otherwise.
REQ-025 Free run with iEN=1 -> oFrameStart every 60 cycles, oLineStart every 10 cycles, exactly 12 oReq per frame.
REQ-026 Requester returns iRed=oX+16*oY two cycles after each request -> oVGA_R is nonzero only while oVGA_BLANK=1, and the first active output R=0x00 appears 3 cycles after the first oReq.
REQ-027 Toggle iEN 1,0,0,1 repeatedly -> frame period is 120 clocks and all outputs hold during iEN=0 cycles.
REQ-028 HS_POL=1, VS_POL=0 -> oVGA_H_SYNC high for 2 enabled cycles per line; oVGA_V_SYNC low for 10 enabled cycles per frame.
REQ-029 Assert iRST_N=0 at hcnt=5, vcnt=3 -> outputs take reset values immediately; after release, oFrameStart=1 on the first enabled cycle.
REQ-030 PIX_LAT=4 -> sync-to-RGB alignment is preserved and latency is 5 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing record, standard mode constants and coordinate width.
package vga_pkg;
   localparam int VGA_COORD_W = 11;
   typedef struct packed {
      int unsigned h_sync, h_back, h_act, h_front;
      int unsigned v_sync, v_back, v_act, v_front;
   } vga_timing_t;
   localparam vga_timing_t VGA_640x480_60 = '{96, 48, 640, 16, 2, 33, 480, 10};
   localparam vga_timing_t VGA_800x600_60 = '{128, 88, 800, 40, 4, 23, 600, 1};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enabled shift register of DEPTH stages, cleared by async reset.
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iEN,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_sr [DEPTH];
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else if (iEN) begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blank generator with a fixed-latency pixel request interface.
module vga_timing_gen import vga_pkg::*; #(
   parameter int H_SYNC  = VGA_640x480_60.h_sync,
   parameter int H_BACK  = VGA_640x480_60.h_back,
   parameter int H_ACT   = VGA_640x480_60.h_act,
   parameter int H_FRONT = VGA_640x480_60.h_front,
   parameter int V_SYNC  = VGA_640x480_60.v_sync,
   parameter int V_BACK  = VGA_640x480_60.v_back,
   parameter int V_ACT   = VGA_640x480_60.v_act,
   parameter int V_FRONT = VGA_640x480_60.v_front,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int COLOR_W = 8,
   parameter int PIX_LAT = 2
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic                   iEN,
   input  logic [COLOR_W-1:0]     iRed,
   input  logic [COLOR_W-1:0]     iGreen,
   input  logic [COLOR_W-1:0]     iBlue,
   output logic                   oReq,
   output logic [VGA_COORD_W-1:0] oX,
   output logic [VGA_COORD_W-1:0] oY,
   output logic                   oLineStart,
   output logic                   oFrameStart,
   output logic [COLOR_W-1:0]     oVGA_R,
   output logic [COLOR_W-1:0]     oVGA_G,
   output logic [COLOR_W-1:0]     oVGA_B,
   output logic                   oVGA_H_SYNC,
   output logic                   oVGA_V_SYNC,
   output logic                   oVGA_BLANK,
   output logic                   oVGA_SYNC,
   output logic                   oVGA_CLK
);
   localparam int CW = VGA_COORD_W + 1;
   localparam logic [CW-1:0] H_HS   = CW'(H_SYNC);
   localparam logic [CW-1:0] H_A0   = CW'(H_SYNC + H_BACK);
   localparam logic [CW-1:0] H_A1   = CW'(H_SYNC + H_BACK + H_ACT);
   localparam logic [CW-1:0] H_LAST = CW'(H_SYNC + H_BACK + H_ACT + H_FRONT - 1);
   localparam logic [CW-1:0] V_VS   = CW'(V_SYNC);
   localparam logic [CW-1:0] V_A0   = CW'(V_SYNC + V_BACK);
   localparam logic [CW-1:0] V_A1   = CW'(V_SYNC + V_BACK + V_ACT);
   localparam logic [CW-1:0] V_LAST = CW'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);

   if (COLOR_W < 1 || COLOR_W > 10) begin : g_bad_color_w
      $error("vga_timing_gen: COLOR_W must be in 1..10");
   end
   if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_pix_lat
      $error("vga_timing_gen: PIX_LAT must be in 1..4");
   end

   logic [CW-1:0]      r_hcnt, r_vcnt;
   logic [COLOR_W-1:0] r_red, r_green, r_blue;
   logic               r_hsync, r_vsync, r_blank;
   logic               w_hlast, w_vlast, w_hs0, w_vs0, w_de0;
   logic [2:0]         w_dl;

   assign w_hlast = (r_hcnt == H_LAST);
   assign w_vlast = (r_vcnt == V_LAST);
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (iEN) begin
         r_hcnt <= w_hlast ? '0 : r_hcnt + 1'b1;
         if (w_hlast) r_vcnt <= w_vlast ? '0 : r_vcnt + 1'b1;
      end

   assign w_hs0 = (r_hcnt < H_HS);
   assign w_vs0 = (r_vcnt < V_VS);
   assign w_de0 = (r_hcnt >= H_A0) && (r_hcnt < H_A1) && (r_vcnt >= V_A0) && (r_vcnt < V_A1);

   assign oReq        = w_de0 & iEN;
   assign oX          = w_de0 ? VGA_COORD_W'(r_hcnt - H_A0) : '0;
   assign oY          = w_de0 ? VGA_COORD_W'(r_vcnt - V_A0) : '0;
   assign oLineStart  = (r_hcnt == '0) & iEN;
   assign oFrameStart = (r_hcnt == '0) & (r_vcnt == '0) & iEN;

   // Sync/blank ride alongside the requester's latency so they meet the returned pixel.
   vga_delay_line #(.WIDTH(3), .DEPTH(PIX_LAT)) u_dl (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iEN    (iEN),
      .i_d    ({w_hs0, w_vs0, w_de0}),
      .o_q    (w_dl)
   );

   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_blank <= 1'b0;
         r_hsync <= ~HS_POL;
         r_vsync <= ~VS_POL;
      end else if (iEN) begin
         r_red   <= w_dl[0] ? iRed   : '0;
         r_green <= w_dl[0] ? iGreen : '0;
         r_blue  <= w_dl[0] ? iBlue  : '0;
         r_blank <= w_dl[0];
         r_hsync <= w_dl[2] ? HS_POL : ~HS_POL;
         r_vsync <= w_dl[1] ? VS_POL : ~VS_POL;
      end

   assign oVGA_R      = r_red;
   assign oVGA_G      = r_green;
   assign oVGA_B      = r_blue;
   assign oVGA_BLANK  = r_blank;
   assign oVGA_H_SYNC = r_hsync;
   assign oVGA_V_SYNC = r_vsync;
   assign oVGA_SYNC   = 1'b0;
   assign oVGA_CLK    = iCLK;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small-timing instances (PIX_LAT 2 and 4) against a positional reference model.
module tb_vga_timing_gen;
   localparam int CW = 8;
   logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
   logic [CW-1:0] ra, ga, ba, rb, gb, bb;
   logic reqA, lsA, fsA, hsA, vsA, blA, syA, ckA;
   logic reqB, lsB, fsB, hsB, vsB, blB, syB, ckB;
   logic [10:0] xA, yA, xB, yB;
   logic [CW-1:0] orA, ogA, obA, orB, ogB, obB;

   always #5 clk = ~clk;

   vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
      .V_ACT(3), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(CW), .PIX_LAT(2)) dut_a (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iRed(ra), .iGreen(ga), .iBlue(ba),
      .oReq(reqA), .oX(xA), .oY(yA), .oLineStart(lsA), .oFrameStart(fsA),
      .oVGA_R(orA), .oVGA_G(ogA), .oVGA_B(obA), .oVGA_H_SYNC(hsA), .oVGA_V_SYNC(vsA),
      .oVGA_BLANK(blA), .oVGA_SYNC(syA), .oVGA_CLK(ckA));

   vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
      .V_ACT(3), .V_FRONT(1), .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(CW), .PIX_LAT(4)) dut_b (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iRed(rb), .iGreen(gb), .iBlue(bb),
      .oReq(reqB), .oX(xB), .oY(yB), .oLineStart(lsB), .oFrameStart(fsB),
      .oVGA_R(orB), .oVGA_G(ogB), .oVGA_B(obB), .oVGA_H_SYNC(hsB), .oVGA_V_SYNC(vsB),
      .oVGA_BLANK(blB), .oVGA_SYNC(syB), .oVGA_CLK(ckB));

   typedef struct packed {logic req; logic [10:0] x, y; logic ls, fs;} comb_t;
   typedef struct packed {logic [CW-1:0] r, g, b; logic hs, vs, blank;} vid_t;
   typedef struct {comb_t c; vid_t v; int ph;} exp_t;
   exp_t qa[$], qb[$];
   exp_t ma, mb;
   int e = 0, cyc = 0, n_chk = 0, n_fail = 0;
   int last_fs = -1, last_ph = 0, nreq = 0;

   // Frame position p in 0..59 of the 10x6 raster; active area is h 4..7, v 2..4.
   function automatic bit act(int p);
      return (p % 10 >= 4) && (p % 10 < 8) && (p / 10 >= 2) && (p / 10 < 5);
   endfunction

   function automatic comb_t comb_m(int cnt, bit on);
      comb_t o;
      int p = cnt % 60;
      o.req = act(p) & on;
      o.x   = act(p) ? 11'(p % 10 - 4) : 11'd0;
      o.y   = act(p) ? 11'(p / 10 - 2) : 11'd0;
      o.ls  = (p % 10 == 0) & on;
      o.fs  = (p == 0) & on;
      return o;
   endfunction

   function automatic vid_t vid_m(int cnt, int lat, bit hp, bit vp);
      vid_t o;
      int p = (cnt - lat - 1) % 60;
      bit a = (cnt >= lat + 1) && act(p);
      o.r = a ? CW'(p % 10 - 4 + 16 * (p / 10 - 2)) : '0;
      o.g = a ? CW'(p % 10 - 4) : '0;
      o.b = a ? CW'(p / 10 - 2) : '0;
      o.hs = (cnt >= lat + 1 && p % 10 < 2) ? hp : ~hp;
      o.vs = (cnt >= lat + 1 && p / 10 < 1) ? vp : ~vp;
      o.blank = a;
      return o;
   endfunction

   // Requester: data for the request made lat enabled cycles ago, noise otherwise.
   function automatic logic [3*CW-1:0] pix(int cnt, int lat);
      int p = cnt - lat;
      if (p >= 0 && act(p % 60))
         return {CW'(p % 60 % 10 - 4 + 16 * (p % 60 / 10 - 2)), CW'(p % 60 % 10 - 4), CW'(p % 60 / 10 - 2)};
      return {CW'($urandom), CW'($urandom), CW'($urandom)};
   endfunction

   task automatic cycle(input bit n_rst, input bit n_en, input int ph);
      exp_t xa, xb;
      @(posedge clk);
      if (rst_n && en) e++;
      #1;
      rst_n = n_rst;
      en = n_en;
      if (!rst_n) e = 0;
      {ra, ga, ba} = pix(e, 2);
      {rb, gb, bb} = pix(e, 4);
      xa.c = comb_m(e, en); xa.v = vid_m(e, 2, 1'b1, 1'b0); xa.ph = ph;
      xb.c = comb_m(e, en); xb.v = vid_m(e, 4, 1'b0, 1'b1); xb.ph = ph;
      qa.push_back(xa);
      qb.push_back(xb);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (qa.size() != 0 && qb.size() != 0) begin
         ma = qa.pop_front();
         mb = qb.pop_front();
         chk("A timing", 32'({reqA, xA, yA, lsA, fsA}), 32'(ma.c));
         chk("A video", 32'({orA, ogA, obA, hsA, vsA, blA}), 32'(ma.v));
         chk("B timing", 32'({reqB, xB, yB, lsB, fsB}), 32'(mb.c));
         chk("B video", 32'({orB, ogB, obB, hsB, vsB, blB}), 32'(mb.v));
         chk("fixed outs", 32'({syA, syB, ckA, ckB}), 32'({1'b0, 1'b0, clk, clk}));
         if (ma.ph == 0) begin
            last_fs = -1;
            nreq = 0;
         end else begin
            if (reqA) nreq++;
            if (fsA) begin
               if (last_fs >= 0) begin
                  chk("requests per frame", 32'(nreq), 32'd12);
                  if (last_ph == ma.ph && ma.ph != 3)
                     chk("frame period", 32'(cyc - last_fs), ma.ph == 1 ? 32'd60 : 32'd120);
               end
               last_fs = cyc;
               last_ph = ma.ph;
               nreq = 0;
            end
         end
      end
   end

   initial begin
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b0, i[0], 0);
      for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1);
      for (int i = 0; i < 300; i++) cycle(1'b1, (i % 4 == 0) || (i % 4 == 3), 2);
      for (int i = 0; i < 250; i++) cycle(1'b1, 1'(($urandom % 4) != 0), 3);
      for (int i = 0; i < 200 && e % 60 != 35; i++) cycle(1'b1, 1'b1, 3);
      cycle(1'b0, 1'b1, 0);
      cycle(1'b0, 1'b0, 0);
      for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
